alu_cmd_sequencer: RTL and testbench

Frame-driven command sequencer that sits directly upstream of the ALU unit stage (arithmetic, logic, compare and shift units) in the final system. It collects operand and function bytes from the UART RX path, drives the ALU operands, function code and exactly one unit enable for one cycle, and captures the registered unit result and flag. It then presents the result byte to the UART TX path over a valid/ready handshake.

---
 rtl/alu_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : UART-frame driven ALU command sequencer (operand/function
//                capture, one-cycle unit enable, result hand-off to TX).
//                Optional WAIT watchdog enabled by defining ALU_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  Arith_Enable,
  output logic                  Logic_Enable,
  output logic                  CMP_Enable,
  output logic                  Shift_Enable,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] c_CMD_FULL  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] c_CMD_REUSE = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_A   = 3'd1,
    S_GET_B   = 3'd2,
    S_GET_FUN = 3'd3,
    S_EXEC    = 3'd4,
    S_WAIT    = 3'd5,
    S_SEND    = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [3:0]            r_alu_fun;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_cmd_err;
  logic                  w_ld_a;
  logic                  w_ld_b;
  logic                  w_ld_fun;
  logic                  w_ld_tx;
  logic                  w_err;
  logic                  w_exec;

`ifdef ALU_TIMEOUT_EN
  localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

  logic [c_WD_W-1:0] r_wd_cnt;

  // Counts cycles spent in WAIT; zero on every entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 r_wd_cnt <= '0;
    else if (r_state != S_WAIT) r_wd_cnt <= '0;
    else                      r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_tx_data <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cmd_err <= w_err;
      if (w_ld_a)   r_alu_a   <= RX_DATA;
      if (w_ld_b)   r_alu_b   <= RX_DATA;
      if (w_ld_fun) r_alu_fun <= RX_DATA[3:0];
      if (w_ld_tx)  r_tx_data <= ALU_OUT;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_fun = 1'b0;
    w_ld_tx  = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RX_VALID) begin
          if (RX_DATA == c_CMD_FULL)       w_next = S_GET_A;
          else if (RX_DATA == c_CMD_REUSE) w_next = S_GET_FUN;
          else                             w_err  = 1'b1;
        end
      end
      S_GET_A: begin
        if (RX_VALID) begin
          w_ld_a = 1'b1;
          w_next = S_GET_B;
        end
      end
      S_GET_B: begin
        if (RX_VALID) begin
          w_ld_b = 1'b1;
          w_next = S_GET_FUN;
        end
      end
      S_GET_FUN: begin
        if (RX_VALID) begin
          w_ld_fun = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        w_err  = RX_VALID;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_err = RX_VALID;
        if (OUT_VALID) begin
          w_ld_tx = 1'b1;
          w_next  = S_SEND;
        end
`ifdef ALU_TIMEOUT_EN
        else if (r_wd_cnt == c_WD_LAST) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
`endif
      end
      S_SEND: begin
        w_err = RX_VALID;
        if (TX_READY) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Unit enables decode straight from state so they last exactly the EXEC cycle.
  assign w_exec       = (r_state == S_EXEC);
  assign Arith_Enable = w_exec && (r_alu_fun[3:2] == 2'b00);
  assign Logic_Enable = w_exec && (r_alu_fun[3:2] == 2'b01);
  assign CMP_Enable   = w_exec && (r_alu_fun[3:2] == 2'b10);
  assign Shift_Enable = w_exec && (r_alu_fun[3:2] == 2'b11);

  assign ALU_A    = r_alu_a;
  assign ALU_B    = r_alu_b;
  assign ALU_FUN  = r_alu_fun;
  assign TX_DATA  = r_tx_data;
  assign TX_VALID = (r_state == S_SEND);
  assign BUSY     = (r_state != S_IDLE);
  assign CMD_ERR  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Scoreboard bench for alu_cmd_sequencer with a registered
//                ALU unit model; watchdog checks follow ALU_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic [7:0] ALU_OUT;
  logic       OUT_VALID;
  logic [7:0] ALU_A, ALU_B, TX_DATA;
  logic [3:0] ALU_FUN;
  logic       Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic       TX_VALID, BUSY, CMD_ERR;
  logic       TX_READY = 1'b1;

  alu_cmd_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_FUN(ALU_FUN), .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         fun_cyc = 0;
  logic       mute = 1'b0;
  logic [7:0] exp_q[$];
  int         n_arith = 0, n_logic = 0, n_cmp = 0, n_shift = 0, n_err = 0, n_multi = 0, n_txv = 0;
  logic       prev_txv = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Registered ALU unit model: result and flag one cycle after the enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      ALU_OUT   <= 8'h00;
    end else begin
      OUT_VALID <= !mute && (Arith_Enable | Logic_Enable | CMP_Enable | Shift_Enable);
      ALU_OUT   <= 8'h00;
      if (!mute && (Arith_Enable | Logic_Enable | CMP_Enable | Shift_Enable)) begin
        case (ALU_FUN)
          4'h0:    ALU_OUT <= ALU_A + ALU_B;
          4'h4:    ALU_OUT <= ALU_A & ALU_B;
          4'hC:    ALU_OUT <= ALU_A >> 1;
          4'hD:    ALU_OUT <= ALU_A << 1;
          default: ALU_OUT <= 8'h00;
        endcase
      end
    end
  end

  // Monitor: scoreboard pop on handshake, latency on TX_VALID rise, pulse counts.
  always @(negedge CLK) begin
    n_arith += int'(Arith_Enable);
    n_logic += int'(Logic_Enable);
    n_cmp   += int'(CMP_Enable);
    n_shift += int'(Shift_Enable);
    n_err   += int'(CMD_ERR);
    n_txv   += int'(TX_VALID);
    if ($countones({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}) > 1) n_multi++;
    if (TX_VALID && !prev_txv) check("tx_latency", 64'(cyc - fun_cyc), 64'd3);
    if (TX_VALID && TX_READY) begin
      if (exp_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
      else check("tx_data", {56'd0, TX_DATA}, {56'd0, exp_q.pop_front()});
    end
    prev_txv = TX_VALID;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic send_fun(input logic [7:0] b);
    fun_cyc = cyc;
    send_byte(b);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (BUSY && n < 50) begin
      tick();
      n++;
    end
    check(nm, {63'd0, BUSY}, 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, ALU_A, ALU_B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable,
            Shift_Enable, TX_DATA, TX_VALID, BUSY, CMD_ERR};
  endfunction

  initial begin
    int s0, e0, w0, busy_low, t0;
    logic seen;
    #2 RST = 1'b0;
    tick(); tick();
    check("reset_outputs", all_outs(), 64'd0);
    RST = 1'b1;
    tick();

    // Full shift frame: SHRA of 0x14 -> 0x0A
    s0 = n_shift;
    exp_q.push_back(8'h0A);
    send_byte(8'hCC);
    check("busy_after_cmd", {63'd0, BUSY}, 64'd1);
    send_byte(8'h14);
    send_byte(8'h03);
    send_fun(8'h0C);
    check("shift_en_exec", {63'd0, Shift_Enable}, 64'd1);
    wait_idle("full_frame_done");
    check("op_regs", {40'd0, ALU_A, ALU_B, 4'd0, ALU_FUN}, {40'd0, 8'h14, 8'h03, 8'h0C});
    check("shift_pulse_count", 64'(n_shift - s0), 64'd1);
    check("no_other_enables", 64'(n_arith + n_logic + n_cmp), 64'd0);

    // Reuse frame: SHLA of held 0x14 -> 0x28
    s0 = n_shift;
    exp_q.push_back(8'h28);
    send_byte(8'hDD);
    send_fun(8'h0D);
    wait_idle("reuse_frame_done");
    check("reuse_a_held", {56'd0, ALU_A}, 64'h14);
    check("reuse_shift_pulse", 64'(n_shift - s0), 64'd1);

    // Illegal command byte in IDLE
    e0 = n_err;
    s0 = n_arith + n_logic + n_cmp + n_shift;
    send_byte(8'h55);
    check("illegal_err", {62'd0, CMD_ERR, BUSY}, 64'b10);
    tick();
    check("illegal_err_one_cycle", {62'd0, CMD_ERR, BUSY}, 64'b00);
    check("illegal_err_count", 64'(n_err - e0), 64'd1);
    check("illegal_no_enable", 64'(n_arith + n_logic + n_cmp + n_shift - s0), 64'd0);

    // Backpressure: ADD 0x05+0x07 -> 0x0C held in SEND, stray RX byte
    TX_READY = 1'b0;
    exp_q.push_back(8'h0C);
    send_byte(8'hCC);
    send_byte(8'h05);
    send_byte(8'h07);
    send_fun(8'h00);
    t0 = 0;
    while (!TX_VALID && t0 < 20) begin
      tick();
      t0++;
    end
    check("bp_tx_valid_seen", {63'd0, TX_VALID}, 64'd1);
    e0 = n_err;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        send_byte(8'h77);
        check("stray_err", {63'd0, CMD_ERR}, 64'd1);
      end else begin
        tick();
      end
      check("bp_stable", {55'd0, TX_VALID, TX_DATA}, {55'd0, 1'b1, 8'h0C});
    end
    check("stray_err_count", 64'(n_err - e0), 64'd1);
    TX_READY = 1'b1;
    tick();
    check("after_handshake_idle", {62'd0, BUSY, TX_VALID}, 64'd0);

    // Reset during WAIT, then a clean frame: ADD 0x10+0x20 -> 0x30
    mute = 1'b1;
    send_byte(8'hCC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_fun(8'h04);
    tick(); tick();
    check("wait_busy", {62'd0, BUSY, TX_VALID}, 64'b10);
    RST = 1'b0;
    #1;
    check("midop_reset_outputs", all_outs(), 64'd0);
    tick(); tick();
    RST  = 1'b1;
    mute = 1'b0;
    exp_q.push_back(8'h30);
    send_byte(8'hCC);
    send_byte(8'h10);
    send_byte(8'h20);
    send_fun(8'h00);
    wait_idle("post_reset_frame_done");

    // Watchdog: unit never answers
    mute = 1'b1;
    w0 = n_txv;
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_fun(8'h0C);
`ifdef ALU_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (CMD_ERR) begin
        seen = 1'b1;
        check("wd_err_time", 64'(cyc - fun_cyc), 64'd18);
        check("wd_busy_dropped", {63'd0, BUSY}, 64'd0);
      end
    end
    check("wd_err_seen", {63'd0, seen}, 64'd1);
`else
    busy_low = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!BUSY) busy_low++;
      if (CMD_ERR) seen = 1'b1;
    end
    check("wd_busy_held", 64'(busy_low), 64'd0);
    check("wd_no_err", {63'd0, seen}, 64'd0);
`endif
    check("wd_no_tx", 64'(n_txv - w0), 64'd0);
    RST = 1'b0;
    tick();
    RST  = 1'b1;
    mute = 1'b0;
    tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("enables_one_hot", 64'(n_multi), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
